// File: rtl/seq_alu.sv
// seq_alu: multi-cycle, width-parametrised ALU with a start/done handshake.
//
// Single-cycle ops (ADD, SUB, AND, OR, shifts, rotates, NEG, NOT), illegal
// opcodes and divide-by-zero complete on the accept edge. MUL (radix-2 Booth)
// and DIV (signed restoring) iterate WIDTH times; the edge performing the last
// iteration also writes the result and pulses done.
//
// Ports:
//   clock        rising-edge system clock
//   clear_n      asynchronous active-low reset
//   start        request, sampled only while idle
//   opcode       5-bit operation, sampled with start
//   ra, rb       WIDTH-bit operands (rb low SHAMT_W bits = shift amount)
//   busy         high while MUL/DIV iterates
//   done         one-cycle pulse: rz and flags were updated this cycle
//   rz           2*WIDTH result, held until the next completion
//   div_by_zero  DIV with rb == 0 (updated with done)
//   illegal_op   unlisted opcode (updated with done)
module seq_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   ra,
  input  logic [WIDTH-1:0]   rb,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] rz,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpMul  = 5'b00010;
  localparam logic [4:0] OpDiv  = 5'b00011;
  localparam logic [4:0] OpAnd  = 5'b00100;
  localparam logic [4:0] OpOr   = 5'b00101;
  localparam logic [4:0] OpShr  = 5'b00110;
  localparam logic [4:0] OpShra = 5'b00111;
  localparam logic [4:0] OpShl  = 5'b01000;
  localparam logic [4:0] OpRor  = 5'b01001;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpNeg  = 5'b01100;
  localparam logic [4:0] OpNot  = 5'b01101;

  // Iteration counter runs 0..WIDTH-1.
  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // acc: Booth partial product (WIDTH+1 bits so -most-negative cannot overflow)
  //      or restoring-division partial remainder.
  // lo:  Booth multiplier / product low half, or dividend shifting into quotient.
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               bit_q, bit_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] rz_q, rz_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [SHAMT_W-1:0] shamt;
  logic [2*WIDTH-1:0] rot_right;
  logic [2*WIDTH-1:0] rot_left;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_legal;

  assign shamt = rb[SHAMT_W-1:0];
  // Rotates as shifts of the operand concatenated with itself.
  assign rot_right = {ra, ra} >> shamt;
  assign rot_left  = {ra, ra} << shamt;

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (opcode)
      OpAdd:  alu_res = ra + rb;
      OpSub:  alu_res = ra - rb;
      OpAnd:  alu_res = ra & rb;
      OpOr:   alu_res = ra | rb;
      OpShr:  alu_res = ra >> shamt;
      OpShra: alu_res = $signed(ra) >>> shamt;
      OpShl:  alu_res = ra << shamt;
      OpRor:  alu_res = rot_right[WIDTH-1:0];
      OpRol:  alu_res = rot_left[2*WIDTH-1:WIDTH];
      OpNeg:  alu_res = -ra;
      OpNot:  alu_res = ~ra;
      // Handled by the FSM; alu_res is not used for these.
      OpMul, OpDiv: alu_res = '0;
      default: alu_legal = 1'b0;
    endcase
  end

  // Operand magnitudes for division; most-negative maps to 2^(WIDTH-1) unsigned.
  logic [WIDTH-1:0] ra_mag;
  logic [WIDTH-1:0] rb_mag;
  assign ra_mag = ra[WIDTH-1] ? -ra : ra;
  assign rb_mag = rb[WIDTH-1] ? -rb : rb;

  // ---------------------------------------------------------------------------
  // Booth iteration
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   opb_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   mul_acc_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  assign opb_ext = {opb_q[WIDTH-1], opb_q};

  always_comb begin
    booth_sum = acc_q;
    case ({lo_q[0], bit_q})
      2'b01:   booth_sum = acc_q + opb_ext;
      2'b10:   booth_sum = acc_q - opb_ext;
      default: booth_sum = acc_q;
    endcase
  end

  // Arithmetic shift right of {acc, lo, bit}.
  assign mul_acc_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign mul_lo_nx  = {booth_sum[0], lo_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // Restoring division iteration
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH:0]   div_acc_nx;
  logic [WIDTH-1:0] div_lo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign div_shift  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign div_fits   = (div_shift >= {1'b0, opb_q});
  assign div_acc_nx = div_fits ? (div_shift - {1'b0, opb_q}) : div_shift;
  assign div_lo_nx  = {lo_q[WIDTH-2:0], div_fits};
  // Quotient negative when signs differ; remainder follows the dividend.
  assign quo_fix    = neg_quo_q ? -div_lo_nx : div_lo_nx;
  assign rem_fix    = neg_rem_q ? -div_acc_nx[WIDTH-1:0] : div_acc_nx[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    bit_d     = bit_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    rz_d      = rz_q;
    dbz_d     = dbz_q;
    ill_d     = ill_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (opcode == OpMul) begin
            state_d = StMul;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = ra;
            opb_d   = rb;
            bit_d   = 1'b0;
          end else if (opcode == OpDiv && rb != '0) begin
            state_d   = StDiv;
            cnt_d     = '0;
            acc_d     = '0;
            lo_d      = ra_mag;
            opb_d     = rb_mag;
            neg_quo_d = ra[WIDTH-1] ^ rb[WIDTH-1];
            neg_rem_d = ra[WIDTH-1];
          end else if (opcode == OpDiv) begin
            done_d = 1'b1;
            rz_d   = {ra, {WIDTH{1'b1}}};
            dbz_d  = 1'b1;
            ill_d  = 1'b0;
          end else begin
            done_d = 1'b1;
            rz_d   = alu_legal ? {{WIDTH{alu_res[WIDTH-1]}}, alu_res} : '0;
            dbz_d  = 1'b0;
            ill_d  = ~alu_legal;
          end
        end
      end

      StMul: begin
        acc_d = mul_acc_nx;
        lo_d  = mul_lo_nx;
        bit_d = lo_q[0];
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          rz_d    = {mul_acc_nx[WIDTH-1:0], mul_lo_nx};
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StDiv: begin
        acc_d = div_acc_nx;
        lo_d  = div_lo_nx;
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          rz_d    = {rem_fix, quo_fix};
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      bit_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      rz_q      <= '0;
      dbz_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      bit_q     <= bit_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      rz_q      <= rz_d;
      dbz_q     <= dbz_d;
      ill_q     <= ill_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign rz          = rz_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule
